// File: rtl/bram_bank_scheduler_pkg.sv
// Shared types and defaults for the BRAM bank scheduler.
// No logic, so no latency.
// No flow control; this file holds only type and width definitions.
package bram_bank_scheduler_pkg;

  // Scheduler phases; 2-bit encoding shared by every file that decodes state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_LUTS_PER_CLOCK  = 2;
  localparam int DEF_BRAM_COUNT      = 2;
  localparam int DEF_BRAM_COUNT_SIZE = 1;
  localparam int DEF_ADDR_SIZE       = 4;
  localparam int DEF_RAM_WIDTH       = 8;

  // Width of a lane index; a single lane still needs one bit.
  function automatic int lane_idx_width(input int lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/bram_bank_scheduler_bank_grant.sv
// Per-bank fixed-priority picker: grants the lowest pending lane targeting BANK.
// Purely combinational, zero latency.
// No flow control; the caller decides when the grant is consumed.
module bram_bank_scheduler_bank_grant
  import bram_bank_scheduler_pkg::*;
#(
  parameter int LANES  = DEF_LUTS_PER_CLOCK,
  parameter int NUM_W  = DEF_BRAM_COUNT_SIZE,
  parameter int ADDR_W = DEF_ADDR_SIZE,
  parameter int BANK   = 0
) (
  input  logic [LANES-1:0]        pending_i,
  input  logic [LANES*NUM_W-1:0]  numbers_i,
  input  logic [LANES*ADDR_W-1:0] addrs_i,
  output logic [LANES-1:0]        grant_o,
  output logic                    en_o,
  output logic [ADDR_W-1:0]       addr_o
);

  logic found;

  // Scan lanes upward; the first pending lane on this bank wins the bank.
  always_comb begin
    found   = 1'b0;
    grant_o = '0;
    addr_o  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!found && pending_i[k] && (int'(numbers_i[k*NUM_W +: NUM_W]) == BANK)) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        addr_o     = addrs_i[k*ADDR_W +: ADDR_W];
      end
    end
    en_o = found;
  end

endmodule

// File: rtl/bram_bank_scheduler.sv
// Shares BRAM banks among a batch of lane requests, serialising bank conflicts over passes.
// Latency: out_valid is high in the cycle P+2 after the accept cycle (P = max lanes on one bank, min 1).
// Backpressure: req_ready only in IDLE; one batch in flight, next accepted the cycle after out_valid.
module bram_bank_scheduler
  import bram_bank_scheduler_pkg::*;
#(
  parameter int LUTS_PER_CLOCK  = DEF_LUTS_PER_CLOCK,
  parameter int BRAM_COUNT      = DEF_BRAM_COUNT,
  parameter int BRAM_COUNT_SIZE = DEF_BRAM_COUNT_SIZE,
  parameter int ADDR_SIZE       = DEF_ADDR_SIZE,
  parameter int RAM_WIDTH       = DEF_RAM_WIDTH,
  localparam int LUT_INDEX_SIZE = lane_idx_width(LUTS_PER_CLOCK)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [LUTS_PER_CLOCK*BRAM_COUNT_SIZE-1:0] req_numbers,
  input  logic [LUTS_PER_CLOCK*ADDR_SIZE-1:0]   req_addrs,
  output logic [BRAM_COUNT-1:0]                 bram_en,
  output logic [BRAM_COUNT*ADDR_SIZE-1:0]       bram_addrs,
  input  logic [BRAM_COUNT*RAM_WIDTH-1:0]       bram_data,
  output logic                                  out_valid,
  output logic [LUTS_PER_CLOCK*RAM_WIDTH-1:0]   out_data,
  output logic [LUT_INDEX_SIZE:0]               pass_count,
  output logic                                  bad_bank
);

  localparam int L   = LUTS_PER_CLOCK;
  localparam int BS  = BRAM_COUNT_SIZE;
  localparam int PCW = LUT_INDEX_SIZE + 1;

  state_e state_q, state_d;

  logic [L*BS-1:0]        numbers_q, numbers_d;
  logic [L*ADDR_SIZE-1:0] addrs_q, addrs_d;
  logic [L-1:0]           pending_q, pending_d;
  logic [L-1:0]           inflight_q, inflight_d;
  logic [L*RAM_WIDTH-1:0] out_data_q, out_data_d;
  logic [PCW-1:0]         pass_count_q, pass_count_d;
  logic                   bad_bank_q, bad_bank_d;

  logic [L-1:0]                  grant_w [BRAM_COUNT];
  logic [BRAM_COUNT-1:0]         en_w;
  logic [BRAM_COUNT*ADDR_SIZE-1:0] addr_w;
  logic [L-1:0]                  grant_all;
  logic [L-1:0]                  illegal;
  logic [L-1:0]                  pending_left;

  // One picker per bank; all see the same pending mask so each lane lands on at most one bank.
  for (genvar b = 0; b < BRAM_COUNT; b++) begin : g_bank
    bram_bank_scheduler_bank_grant #(
      .LANES  (L),
      .NUM_W  (BS),
      .ADDR_W (ADDR_SIZE),
      .BANK   (b)
    ) u_grant (
      .pending_i (pending_q),
      .numbers_i (numbers_q),
      .addrs_i   (addrs_q),
      .grant_o   (grant_w[b]),
      .en_o      (en_w[b]),
      .addr_o    (addr_w[b*ADDR_SIZE +: ADDR_SIZE])
    );
  end

  // Merge per-bank grants and flag pending lanes whose bank number does not exist.
  always_comb begin
    grant_all = '0;
    illegal   = '0;
    for (int b = 0; b < BRAM_COUNT; b++) begin
      grant_all = grant_all | grant_w[b];
    end
    for (int k = 0; k < L; k++) begin
      illegal[k] = pending_q[k] && (int'(numbers_q[k*BS +: BS]) >= BRAM_COUNT);
    end
    // Illegal lanes retire on their first issue edge without ever being read.
    pending_left = pending_q & ~grant_all & ~illegal;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: stay in ISSUE until every lane has been granted or retired.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (pending_left == '0) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state; bank ports are driven only while issuing.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    out_valid  = (state_q == ST_DONE);
    bram_en    = '0;
    bram_addrs = '0;
    if (state_q == ST_ISSUE) begin
      bram_en    = en_w;
      bram_addrs = addr_w;
    end
  end

  // Datapath next-state: latch batch, retire grants, collect read words one cycle after issue.
  always_comb begin
    numbers_d    = numbers_q;
    addrs_d      = addrs_q;
    pending_d    = pending_q;
    inflight_d   = inflight_q;
    out_data_d   = out_data_q;
    pass_count_d = pass_count_q;
    bad_bank_d   = bad_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          numbers_d    = req_numbers;
          addrs_d      = req_addrs;
          pending_d    = '1;
          inflight_d   = '0;
          out_data_d   = '0;
          pass_count_d = '0;
          bad_bank_d   = 1'b0;
        end
      end
      ST_ISSUE, ST_DRAIN: begin
        // Words for last cycle's grants are on bram_data now; route each back to its lane.
        for (int k = 0; k < L; k++) begin
          for (int b = 0; b < BRAM_COUNT; b++) begin
            if (inflight_q[k] && (int'(numbers_q[k*BS +: BS]) == b)) begin
              out_data_d[k*RAM_WIDTH +: RAM_WIDTH] = bram_data[b*RAM_WIDTH +: RAM_WIDTH];
            end
          end
        end
        if (state_q == ST_ISSUE) begin
          pending_d  = pending_left;
          inflight_d = grant_all;
          if (grant_all != '0) pass_count_d = pass_count_q + {{(PCW-1){1'b0}}, 1'b1};
          if (illegal != '0)   bad_bank_d   = 1'b1;
        end else begin
          inflight_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any batch in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      numbers_q    <= '0;
      addrs_q      <= '0;
      pending_q    <= '0;
      inflight_q   <= '0;
      out_data_q   <= '0;
      pass_count_q <= '0;
      bad_bank_q   <= 1'b0;
    end else begin
      numbers_q    <= numbers_d;
      addrs_q      <= addrs_d;
      pending_q    <= pending_d;
      inflight_q   <= inflight_d;
      out_data_q   <= out_data_d;
      pass_count_q <= pass_count_d;
      bad_bank_q   <= bad_bank_d;
    end
  end

  assign out_data   = out_data_q;
  assign pass_count = pass_count_q;
  assign bad_bank   = bad_bank_q;

endmodule

// File: tb/tb_bram_bank_scheduler.sv
// Bench for bram_bank_scheduler: directed cases then random batches against a per-bank counting model.
// Three banks with 2-bit bank numbers, so bank 3 exercises the illegal-bank path.
// BRAM is modelled as a one-cycle registered read from a bench memory.
module tb_bram_bank_scheduler;

  localparam int L   = 2;
  localparam int NB  = 3;
  localparam int BS  = 2;
  localparam int AS  = 4;
  localparam int RW  = 8;
  localparam int PCW = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [L*BS-1:0]   req_numbers;
  logic [L*AS-1:0]   req_addrs;
  logic [NB-1:0]     bram_en;
  logic [NB*AS-1:0]  bram_addrs;
  logic [NB*RW-1:0]  bram_data;
  logic              out_valid;
  logic [L*RW-1:0]   out_data;
  logic [PCW-1:0]    pass_count;
  logic              bad_bank;

  int n_vec = 0;
  int n_bad = 0;

  logic [RW-1:0] mem [NB][16];

  bram_bank_scheduler #(
    .LUTS_PER_CLOCK  (L),
    .BRAM_COUNT      (NB),
    .BRAM_COUNT_SIZE (BS),
    .ADDR_SIZE       (AS),
    .RAM_WIDTH       (RW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_numbers (req_numbers),
    .req_addrs   (req_addrs),
    .bram_en     (bram_en),
    .bram_addrs  (bram_addrs),
    .bram_data   (bram_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .pass_count  (pass_count),
    .bad_bank    (bad_bank)
  );

  always #5 clock = ~clock;

  // BRAM model: data appears the cycle after an enabled edge.
  always @(posedge clock) begin
    for (int b = 0; b < NB; b++) begin
      if (bram_en[b]) bram_data[b*RW +: RW] <= mem[b][bram_addrs[b*AS +: AS]];
    end
  end

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  // Present one batch, wait for accept, follow it to out_valid and compare with the model.
  // hold=1 keeps req_valid high with scrambled data after accept; exp_wait>=0 checks accept delay.
  task automatic do_batch(input string tag, input logic [L*BS-1:0] nums,
                          input logic [L*AS-1:0] adrs, input bit hold, input int exp_wait);
    logic [L*RW-1:0] exp_data;
    int              exp_cnt  [NB];
    logic [AS-1:0]   exp_addr [NB][L];
    int              got_cnt  [NB];
    logic [AS-1:0]   got_addr [NB][L];
    bit              exp_bad;
    int              exp_p;
    int              waited;
    int              c;
    bit              seen;
    int              stray;
    int              bank;

    // Reference model: per-bank request lists in lane order; passes = longest list.
    exp_data = '0;
    exp_bad  = 1'b0;
    exp_p    = 0;
    stray    = 0;
    for (int b = 0; b < NB; b++) begin
      exp_cnt[b] = 0;
      got_cnt[b] = 0;
      for (int i = 0; i < L; i++) begin
        exp_addr[b][i] = '0;
        got_addr[b][i] = '0;
      end
    end
    for (int k = 0; k < L; k++) begin
      bank = int'(nums[k*BS +: BS]);
      if (bank >= NB) begin
        exp_bad = 1'b1;
      end else begin
        exp_data[k*RW +: RW] = mem[bank][adrs[k*AS +: AS]];
        exp_addr[bank][exp_cnt[bank]] = adrs[k*AS +: AS];
        exp_cnt[bank]++;
      end
    end
    for (int b = 0; b < NB; b++) if (exp_cnt[b] > exp_p) exp_p = exp_cnt[b];

    req_numbers = nums;
    req_addrs   = adrs;
    req_valid   = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    check(tag, "ready", req_ready, 1);
    if (exp_wait >= 0) check(tag, "accept_wait", waited, exp_wait);

    // Accept edge; afterwards we are in cycle 1 relative to the accept cycle.
    @(posedge clock); #1;
    if (!hold) req_valid = 1'b0;
    seen = 1'b0;
    for (c = 1; c <= 12; c++) begin
      if (hold) begin
        req_numbers = 4'($urandom);
        req_addrs   = 8'($urandom);
      end
      for (int b = 0; b < NB; b++) begin
        if (bram_en[b]) begin
          if (got_cnt[b] < L) got_addr[b][got_cnt[b]] = bram_addrs[b*AS +: AS];
          got_cnt[b]++;
        end else if (bram_addrs[b*AS +: AS] != '0) begin
          stray++;
        end
      end
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end

    check(tag, "latency", seen ? c : 0, ((exp_p < 1) ? 1 : exp_p) + 2);
    check(tag, "out_data", out_data, exp_data);
    check(tag, "pass_count", pass_count, exp_p);
    check(tag, "bad_bank", bad_bank, exp_bad);
    check(tag, "ready_in_done", req_ready, 0);
    check(tag, "idle_bank_addr", stray, 0);
    for (int b = 0; b < NB; b++) begin
      check(tag, $sformatf("bank%0d_reads", b), got_cnt[b], exp_cnt[b]);
      for (int i = 0; i < exp_cnt[b]; i++) begin
        check(tag, $sformatf("bank%0d_addr%0d", b, i), got_addr[b][i], exp_addr[b][i]);
      end
    end

    @(posedge clock); #1;
    check(tag, "pulse_end", out_valid, 0);
    check(tag, "ready_after", req_ready, 1);
    check(tag, "data_held", out_data, exp_data);
  endtask

  initial begin
    bit ov_seen;

    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 16; a++)
        mem[b][a] = 8'($urandom);
    mem[0][3] = 8'hA1;
    mem[1][5] = 8'hB2;
    mem[1][2] = 8'h11;
    mem[1][7] = 8'h77;
    mem[2][4] = 8'h4C;

    // Reset state.
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_numbers = '0;
    req_addrs   = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset", "req_ready", req_ready, 1);
    check("reset", "bram_en", bram_en, 0);
    check("reset", "bram_addrs", bram_addrs, 0);
    check("reset", "out_valid", out_valid, 0);
    check("reset", "out_data", out_data, 0);
    check("reset", "pass_count", pass_count, 0);
    check("reset", "bad_bank", bad_bank, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // No conflict: one pass, both banks enabled together.
    do_batch("t1", {2'd1, 2'd0}, {4'd5, 4'd3}, 1'b0, -1);
    check("t1", "literal_data", out_data, 16'hB2A1);

    // Same bank twice: two passes in lane order.
    do_batch("t2", {2'd1, 2'd1}, {4'd7, 4'd2}, 1'b0, -1);
    check("t2", "literal_data", out_data, 16'h7711);

    // Reset in the middle of a conflicting batch.
    req_numbers = {2'd1, 2'd1};
    req_addrs   = {4'd7, 4'd2};
    req_valid   = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("t3", "issue1_en", bram_en, 3'b010);
    check("t3", "issue1_addr", bram_addrs, 12'h020);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("t3", "bram_en", bram_en, 0);
    check("t3", "req_ready", req_ready, 1);
    check("t3", "out_data", out_data, 0);
    check("t3", "pass_count", pass_count, 0);
    reset_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      ov_seen = ov_seen | out_valid;
    end
    check("t3", "no_out_valid", ov_seen, 0);

    // req_valid never drops: second batch taken only in the cycle after out_valid.
    do_batch("t4a", {2'd0, 2'd0}, {4'd9, 4'd3}, 1'b1, -1);
    do_batch("t4b", {2'd2, 2'd1}, {4'd4, 4'd5}, 1'b0, 0);

    // Illegal bank on lane 0.
    do_batch("t5", {2'd2, 2'd3}, {4'd4, 4'd1}, 1'b0, -1);
    check("t5", "literal_data", out_data, 16'h4C00);

    // Random batches with idle gaps.
    for (int n = 0; n < 150; n++) begin
      logic [L*BS-1:0] rn;
      logic [L*AS-1:0] ra;
      int gap;
      rn  = 4'($urandom);
      ra  = 8'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clock);
      #1;
      do_batch($sformatf("rnd%0d", n), rn, ra, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
